// File: rtl/mc_if.sv
// mc_if: instruction/status fields into, and datapath controls out of, the multicycle controller.
interface mc_if #(
    parameter int unsigned ALUCTRL_W = 4
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 IRWrite;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 AdrSrc;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 illegal_instr;
    logic                 bus_err;
    logic [3:0]           state;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        output illegal_instr, bus_err, state
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        input  illegal_instr, bus_err, state
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V main control FSM with memory-wait watchdog and sticky traps.
// Define MC_CTRL_SHIFT_EN to accept sll/srl/sra in the ALU instruction classes.
module mc_controller #(
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned MAX_WAIT  = 15
) (
    input logic  clk,
    input logic  reset,
    mc_if.master bus
);
    localparam int unsigned CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_I     = 7'b0010011;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [6:0]  OP_BR    = 7'b1100011;
`ifdef MC_CTRL_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5,  EXECUTER = 4'd6, EXECUTEI = 4'd7,
        ALUWB    = 4'd8,  JAL      = 4'd9,  BRANCH = 4'd10, TRAP = 4'd11
    } state_t;

    state_t           state_q;
    state_t           out_state;
    state_t           decode_next;
    state_t           wait_exit;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_last;
    logic             alu_f3_ok;
    logic             br_f3_ok;
    logic             illegal_q;
    logic             bus_err_q;
    logic [3:0]       exec_alu;
    logic [3:0]       alu_op;

    assign wait_last = (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign alu_f3_ok = (bus.funct3 != 3'b011) &&
                       (SHIFT_EN || ((bus.funct3 != 3'b001) && (bus.funct3 != 3'b101)));
    assign br_f3_ok  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);

    // Opcode/funct3 legality check; anything unrecognised traps.
    always_comb begin
        decode_next = TRAP;
        case (bus.op)
            OP_LOAD, OP_STORE: decode_next = MEMADR;
            OP_R:              if (alu_f3_ok) decode_next = EXECUTER;
            OP_I:              if (alu_f3_ok) decode_next = EXECUTEI;
            OP_JAL:            decode_next = JAL;
            OP_BR:             if (br_f3_ok) decode_next = BRANCH;
            default:           ;
        endcase
    end

    always_comb begin
        wait_exit = FETCH;
        case (state_q)
            FETCH:   wait_exit = DECODE;
            MEMREAD: wait_exit = MEMWB;
            default: wait_exit = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH, MEMREAD, MEMWRITE: begin
                    // Watchdog: the MAX_WAIT-th consecutive not-ready cycle is a bus error.
                    if (bus.mem_ready) begin
                        state_q  <= wait_exit;
                        wait_cnt <= '0;
                    end else if (wait_last) begin
                        state_q   <= TRAP;
                        wait_cnt  <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    state_q <= decode_next;
                    if (decode_next == TRAP) illegal_q <= 1'b1;
                end
                MEMADR:                  state_q <= bus.op[5] ? MEMWRITE : MEMREAD;
                MEMWB, ALUWB, BRANCH:    state_q <= FETCH;
                EXECUTER, EXECUTEI, JAL: state_q <= ALUWB;
                TRAP:                    state_q <= TRAP;
                default:                 state_q <= TRAP;
            endcase
        end
    end

    always_comb begin
        exec_alu = 4'b0000;
        case (bus.funct3)
            3'b000:  exec_alu = (bus.op[5] && bus.funct7b5) ? 4'b0001 : 4'b0000;
            3'b001:  if (SHIFT_EN) exec_alu = 4'b0110;
            3'b010:  exec_alu = 4'b0101;
            3'b100:  exec_alu = 4'b0100;
            3'b101:  if (SHIFT_EN) exec_alu = bus.funct7b5 ? 4'b1000 : 4'b0111;
            3'b110:  exec_alu = 4'b0011;
            3'b111:  exec_alu = 4'b0010;
            default: exec_alu = 4'b0000;
        endcase
    end

    // Moore decode; during reset the selects show FETCH and all strobes are held low.
    always_comb begin
        out_state     = reset ? FETCH : state_q;
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        alu_op        = 4'b0000;
        case (out_state)
            FETCH: begin
                bus.PCWrite   = bus.mem_ready;
                bus.IRWrite   = bus.mem_ready;
                bus.ResultSrc = 2'b10;
                bus.ALUSrcB   = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD: bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXECUTER, EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = (out_state == EXECUTEI) ? 2'b01 : 2'b00;
                alu_op      = exec_alu;
            end
            ALUWB: bus.RegWrite = 1'b1;
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 4'b0001;
                bus.PCWrite = ((bus.funct3 == 3'b000) && bus.zero) ||
                              ((bus.funct3 == 3'b001) && !bus.zero);
            end
            default: ;
        endcase
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
        end
        bus.ALUControl = ALUCTRL_W'(alu_op);
    end

    always_comb begin
        case (bus.op)
            OP_STORE: bus.ImmSrc = 2'b01;
            OP_BR:    bus.ImmSrc = 2'b10;
            OP_JAL:   bus.ImmSrc = 2'b11;
            default:  bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.illegal_instr = illegal_q;
    assign bus.bus_err       = bus_err_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-instruction expected state/control traces built from the instruction
// semantics, compared cycle by cycle against mc_controller under random and directed stimulus.
module tb_mc_controller;
    localparam int unsigned ALUCTRL_W = 4;
    localparam int unsigned MAX_WAIT  = 15;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8, S_JAL = 4'd9, S_BRANCH = 4'd10, S_TRAP = 4'd11;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_if #(.ALUCTRL_W(ALUCTRL_W)) bus ();
    mc_controller #(.ALUCTRL_W(ALUCTRL_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       cur_z;
    int         cur_cause;    // 0 none, 1 illegal instruction, 2 bus error
    logic [3:0] exp_st[$];
    logic       exp_rdy[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    endtask

    function automatic logic alu_ok(input logic [2:0] f3);
        if (f3 == 3'b011) return 1'b0;
`ifdef MC_CTRL_SHIFT_EN
        return 1'b1;
`else
        return !(f3 == 3'b001 || f3 == 3'b101);
`endif
    endfunction

    // Mnemonic table: add/sub, sll, slt, xor, srl/sra, or, and.
    function automatic logic [3:0] alu_exp(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (op[5] && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd8 : 4'd7;
            3'd6:    return 4'd3;
            3'd7:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] imm_exp(input logic [6:0] op);
        if (op == OP_STORE) return 2'b01;
        if (op == OP_BR)    return 2'b10;
        if (op == OP_JAL)   return 2'b11;
        return 2'b00;
    endfunction

    task automatic push(input logic [3:0] s, input logic r);
        exp_st.push_back(s);
        exp_rdy.push_back(r);
    endtask

    task automatic push_wait(input logic [3:0] s, input int nz, output bit timed_out);
        timed_out = 1'b0;
        if (nz >= int'(MAX_WAIT)) begin
            for (int i = 0; i < int'(MAX_WAIT); i++) push(s, 1'b0);
            timed_out = 1'b1;
        end else begin
            for (int i = 0; i < nz; i++) push(s, 1'b0);
            push(s, 1'b1);
        end
    endtask

    // Expected state trace of one instruction, with the mem_ready value to drive each cycle.
    task automatic build(input int fw, input int mw);
        bit to;
        exp_st.delete();
        exp_rdy.delete();
        cur_cause = 0;
        push_wait(S_FETCH, fw, to);
        if (to) cur_cause = 2;
        else begin
            push(S_DECODE, 1'($urandom));
            case (cur_op)
                OP_LOAD: begin
                    push(S_MEMADR, 1'($urandom));
                    push_wait(S_MEMREAD, mw, to);
                    if (to) cur_cause = 2; else push(S_MEMWB, 1'($urandom));
                end
                OP_STORE: begin
                    push(S_MEMADR, 1'($urandom));
                    push_wait(S_MEMWRITE, mw, to);
                    if (to) cur_cause = 2;
                end
                OP_R, OP_I: begin
                    if (alu_ok(cur_f3)) begin
                        push((cur_op == OP_R) ? S_EXECR : S_EXECI, 1'($urandom));
                        push(S_ALUWB, 1'($urandom));
                    end else cur_cause = 1;
                end
                OP_JAL: begin
                    push(S_JAL, 1'($urandom));
                    push(S_ALUWB, 1'($urandom));
                end
                OP_BR: begin
                    if (cur_f3 == 3'd0 || cur_f3 == 3'd1) push(S_BRANCH, 1'($urandom));
                    else cur_cause = 1;
                end
                default: cur_cause = 1;
            endcase
        end
        if (cur_cause != 0) repeat (3) push(S_TRAP, 1'($urandom));
    endtask

    task automatic check_cycle(input logic [3:0] s, input logic r);
        logic pc, ir, rw, mwr, adr, il, be;
        logic [1:0] rs, a, b;
        logic [3:0] alu;
        {pc, ir, rw, mwr, adr} = 5'b0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = 4'd0;
        case (s)
            S_FETCH:    begin pc = r; ir = r; rs = 2'b10; b = 2'b10; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  adr = 1'b1;
            S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; mwr = 1'b1; end
            S_EXECR:    begin a = 2'b10; alu = alu_exp(cur_op, cur_f3, cur_f7); end
            S_EXECI:    begin a = 2'b10; b = 2'b01; alu = alu_exp(cur_op, cur_f3, cur_f7); end
            S_ALUWB:    rw = 1'b1;
            S_JAL:      begin a = 2'b01; b = 2'b10; pc = 1'b1; end
            S_BRANCH:   begin a = 2'b10; alu = 4'd1; pc = (cur_f3 == 3'd0) ? cur_z : !cur_z; end
            default:    ;
        endcase
        il = (s == S_TRAP) && (cur_cause == 1);
        be = (s == S_TRAP) && (cur_cause == 2);
        chk("state", 32'(bus.state), 32'(s));
        chk("strobes", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc}),
            32'({pc, ir, rw, mwr, adr}));
        chk("selects", 32'({bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB}), 32'({rs, a, b}));
        chk("alucontrol", 32'(bus.ALUControl), 32'(alu));
        chk("immsrc", 32'(bus.ImmSrc), 32'(imm_exp(cur_op)));
        chk("flags", 32'({bus.illegal_instr, bus.bus_err}), 32'({il, be}));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'($urandom);
        #1;
        chk("rst_strobes", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 32'd0);
        chk("rst_selects", 32'({bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB}), 32'b0_10_00_10);
        chk("rst_alu", 32'(bus.ALUControl), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 32'(S_FETCH));
        chk("rst_flags", 32'({bus.illegal_instr, bus.bus_err}), 32'd0);
        reset = 1'b0;
    endtask

    // Run one instruction; cut>0 aborts with reset after that many cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input int cut);
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
        build(fw, mw);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        for (int i = 0; i < exp_st.size(); i++) begin
            if (cut > 0 && i >= cut) break;
            bus.mem_ready = exp_rdy[i];
            #1;
            check_cycle(exp_st[i], exp_rdy[i]);
            @(posedge clk);
            #1;
        end
        if (cur_cause != 0 || cut > 0) do_reset();
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int k;
        reset = 1'b1;
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_state", 32'(bus.state), 32'(S_FETCH));
        chk("init_flags", 32'({bus.illegal_instr, bus.bus_err}), 32'd0);
        reset = 1'b0;

        run_instr(OP_R, 3'd0, 1'b0, 1'b0, 0, 0, 0);           // add
        run_instr(OP_R, 3'd0, 1'b1, 1'b0, 1, 0, 0);           // sub
        run_instr(OP_I, 3'd0, 1'b1, 1'b0, 0, 0, 0);           // addi never subtracts
        run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, 3, 0);        // lw, 3 wait cycles
        run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, int'(MAX_WAIT) - 1, 0);
        run_instr(OP_BR, 3'd0, 1'b0, 1'b1, 0, 0, 0);          // beq taken
        run_instr(OP_BR, 3'd1, 1'b0, 1'b1, 0, 0, 0);          // bne not taken
        run_instr(OP_BR, 3'd4, 1'b0, 1'b0, 0, 0, 0);          // blt -> trap
        run_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 0, int'(MAX_WAIT), 0);
        run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 2, 0, 0);
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 0);     // illegal opcode
        run_instr(OP_R, 3'd5, 1'b1, 1'b0, 0, 0, 0);           // sra
        run_instr(OP_I, 3'd1, 1'b0, 1'b0, 0, 0, 0);           // slli
        run_instr(OP_R, 3'd3, 1'b0, 1'b0, 0, 0, 0);           // sltu -> trap
        run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, int'(MAX_WAIT), 0, 0);
        run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1, 10, 7);       // reset mid-wait

        for (int n = 0; n < 80; n++) begin
            k  = int'($urandom_range(0, 6));
            f3 = 3'($urandom);
            op = OP_R;
            case (k)
                0: op = OP_LOAD;
                1: op = OP_STORE;
                2: op = OP_R;
                3: op = OP_I;
                4: op = OP_JAL;
                5: begin
                    op = OP_BR;
                    if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
                end
                default: begin
                    op = 7'($urandom);
                    if (op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BR}) op = 7'b1111111;
                end
            endcase
            run_instr(op, f3, 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 4, ALUControl width (legal range >=4; upper bits zero-extended).
REQ-002 SHALL have parameter MAX_WAIT, default 15, max memory wait cycles before bus error (>=1).
REQ-003 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have op / funct3 / funct7b5  input  7/3/1  fields of the instruction register.
REQ-006 SHALL have zero  input  1  ALU zero flag; mem_ready  input  1  memory completes access this cycle.
REQ-007 SHALL have PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath strobes/select.
REQ-008 SHALL have ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath selects.
REQ-009 SHALL have ALUControl  output  ALUCTRL_W  ALU operation.
REQ-010 SHALL have illegal_instr, bus_err  output  1 each  sticky trap flags; state  output  4  FSM state (debug).

Function
REQ-011 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH, TRAP.
REQ-012 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay until mem_ready, then DECODE.
REQ-013 DECODE: ALUSrcA=01, ALUSrcB=01, add; next by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BRANCH, any other->TRAP with illegal_instr.
REQ-014 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op[5]=0->MEMREAD, else MEMWRITE.
REQ-015 MEMREAD: ResultSrc=00, AdrSrc=1; mem_ready->MEMWB. MEMWB: ResultSrc=01, RegWrite=1 ->FETCH.
REQ-016 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 every cycle in state; mem_ready->FETCH.
REQ-017 EXECUTER: ALUSrcA=10, ALUSrcB=00; EXECUTEI: ALUSrcA=10, ALUSrcB=01; both ->ALUWB. ALUWB: ResultSrc=00, RegWrite=1 ->FETCH.
REQ-018 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 ->ALUWB.
REQ-019 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=(funct3=000&zero)|(funct3=001&!zero) ->FETCH; DECODE SHALL send other branch funct3 to TRAP.
REQ-020 ALUControl in EXECUTER/EXECUTEI: funct3 000 add (sub if op[5]&funct7b5), 010 slt=0101, 100 xor=0100, 110 or=0011, 111 and=0010; add=0000, sub=0001; 011 SHALL trap in DECODE.
REQ-021 ImmSrc SHALL decode from op combinationally in all states: I-type 00, store 01, branch 10, jal 11, else 00.
REQ-022 Wait counter SHALL clear on entry to FETCH/MEMREAD/MEMWRITE and increment each cycle mem_ready=0 there; reaching MAX_WAIT with mem_ready=0 SHALL go TRAP and set bus_err.
REQ-023 TRAP: all strobes 0; illegal_instr/bus_err held; exits only on reset.
REQ-024 Unlisted outputs in any state SHALL be 0; strobes SHALL never assert in TRAP.

Reset
REQ-025 reset SHALL force state=FETCH, wait counter=0, illegal_instr=bus_err=0 at next edge, overriding any transition incl. mid-wait or TRAP.
REQ-026 While reset=1 PCWrite, IRWrite, RegWrite, MemWrite SHALL be 0; other outputs take FETCH values.

Configuration
REQ-027 With MC_CTRL_SHIFT_EN defined, funct3 001 SHALL give sll=0110, 101 srl=0111 or sra=1000 (funct7b5=1) in EXECUTER/EXECUTEI.
REQ-028 Without MC_CTRL_SHIFT_EN, ALU-class funct3 001/101 SHALL go DECODE->TRAP with illegal_instr=1.

Verification
REQ-029 add (op=0110011,f3=000,f7b5=0), mem_ready=1 -> FETCH,DECODE,EXECUTER,ALUWB; ALUControl=0000; RegWrite=1 in ALUWB only.
REQ-030 lw, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MEMWB RegWrite=1, ResultSrc=01, total 8 cycles.
REQ-031 beq zero=1 -> PCWrite=1 in BRANCH; bne zero=1 -> PCWrite=0; f3=100 -> TRAP.
REQ-032 sw with mem_ready=0 for 15 cycles -> bus_err=1, TRAP, MemWrite=0 thereafter; reset -> FETCH, flags 0.
REQ-033 op=1111111 -> illegal_instr=1 after DECODE; sra (f3=101,f7b5=1) -> 1000 with macro, TRAP without.
